// File: rtl/coproc_pkg.sv
// ============================================================================
// Module      : coproc_pkg
// Description : Shared definitions for the matrix coprocessor address path:
//               matrix type codes, config field positions, sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coproc_pkg;

    // One-hot matrix selectors
    localparam logic [2:0] TYPE_A = 3'b001;
    localparam logic [2:0] TYPE_B = 3'b010;
    localparam logic [2:0] TYPE_C = 3'b100;

    // Config word field positions, in units of the field width, from the LSB
    localparam int unsigned FLD_LAMBDA = 0;
    localparam int unsigned FLD_GAMMA  = 1;
    localparam int unsigned FLD_MU     = 2;
    localparam int unsigned FLD_PROCS  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } seq_state_e;

    // Extract field number fld of width w from a packed config word
    function automatic logic [63:0] cfg_field(input logic [63:0] word,
                                              input int unsigned fld,
                                              input int unsigned w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (word >> (fld * w)) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_base_calc.sv
// ============================================================================
// Module      : tile_base_calc
// Description : Combinational tile setup: matrix base, row pitch, start
//               address of the tile origin and command legality.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_base_calc
    import coproc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 8,
    parameter int CFG_W  = 32
) (
    input  logic [CFG_W-1:0]  cfg_i,
    input  logic [2:0]        type_i,
    input  logic [IDX_W-1:0]  row_start_i,
    input  logic [IDX_W-1:0]  col_start_i,
    input  logic [IDX_W-1:0]  tile_rows_i,
    input  logic [IDX_W-1:0]  tile_cols_i,
    output logic [IDX_W-1:0]  ncols_o,
    output logic [ADDR_W-1:0] start_o,
    output logic              legal_o
);

    // Wide enough that no product or sum of legal-looking fields can wrap
    localparam int WW = ADDR_W + IDX_W;
    localparam logic [WW-1:0] C_LIMIT = WW'(1) << ADDR_W;

    logic [IDX_W-1:0] w_lambda, w_gamma, w_mu;
    logic [WW-1:0]    w_base_b, w_base_c, w_end, w_base, w_start;
    logic [IDX_W-1:0] w_ncols, w_nrows;
    logic             w_type_ok, w_dims_ok, w_rows_ok, w_cols_ok, w_fit_ok;

    assign w_lambda = IDX_W'(cfg_field(64'(cfg_i), FLD_LAMBDA, IDX_W));
    assign w_gamma  = IDX_W'(cfg_field(64'(cfg_i), FLD_GAMMA,  IDX_W));
    assign w_mu     = IDX_W'(cfg_field(64'(cfg_i), FLD_MU,     IDX_W));

    assign w_base_b = WW'(w_lambda) * WW'(w_gamma);
    assign w_base_c = w_base_b + WW'(w_gamma) * WW'(w_mu);
    assign w_end    = w_base_c + WW'(w_lambda) * WW'(w_mu);

    // Per-matrix base and shape; a non-one-hot type selects nothing
    always_comb begin
        w_base    = '0;
        w_ncols   = '0;
        w_nrows   = '0;
        w_type_ok = 1'b0;
        case (type_i)
            TYPE_A: begin w_base = '0;       w_ncols = w_gamma; w_nrows = w_lambda; w_type_ok = 1'b1; end
            TYPE_B: begin w_base = w_base_b; w_ncols = w_mu;    w_nrows = w_gamma;  w_type_ok = 1'b1; end
            TYPE_C: begin w_base = w_base_c; w_ncols = w_mu;    w_nrows = w_lambda; w_type_ok = 1'b1; end
            default: ;
        endcase
    end

    assign w_start   = w_base + WW'(row_start_i) * WW'(w_ncols) + WW'(col_start_i);
    assign w_dims_ok = (w_lambda != '0) && (w_gamma != '0) && (w_mu != '0) &&
                       (tile_rows_i != '0) && (tile_cols_i != '0);
    assign w_rows_ok = ({1'b0, row_start_i} + {1'b0, tile_rows_i}) <= {1'b0, w_nrows};
    assign w_cols_ok = ({1'b0, col_start_i} + {1'b0, tile_cols_i}) <= {1'b0, w_ncols};
    assign w_fit_ok  = (w_end <= C_LIMIT);

    assign ncols_o = w_ncols;
    assign start_o = ADDR_W'(w_start);
    assign legal_o = w_type_ok && w_dims_ok && w_rows_ok && w_cols_ok && w_fit_ok;

endmodule

`default_nettype wire

// File: rtl/tile_address_sequencer.sv
// ============================================================================
// Module      : tile_address_sequencer
// Description : Accepts a tile command and streams one SRAM address per beat
//               over valid/ready, walking the tile row- or column-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_address_sequencer
    import coproc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 8,
    parameter int CFG_W  = 32
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [CFG_W-1:0]  i_Config,
    input  logic              i_Cmd_Valid,
    output logic              o_Cmd_Ready,
    input  logic [2:0]        i_Type,
    input  logic [IDX_W-1:0]  i_Row_Start,
    input  logic [IDX_W-1:0]  i_Col_Start,
    input  logic [IDX_W-1:0]  i_Tile_Rows,
    input  logic [IDX_W-1:0]  i_Tile_Cols,
    input  logic              i_Col_Major,
    output logic              o_Addr_Valid,
    input  logic              i_Addr_Ready,
    output logic [ADDR_W-1:0] o_Address,
    output logic [IDX_W-1:0]  o_Row,
    output logic [IDX_W-1:0]  o_Col,
    output logic              o_Last,
    output logic              o_Err
);

    seq_state_e        state_q;
    logic              pend_q;
    logic [CFG_W-1:0]  cfg_q;
    logic [2:0]        type_q;
    logic [IDX_W-1:0]  row_start_q, col_start_q, trows_q, tcols_q;
    logic              cmaj_q;
    logic [IDX_W-1:0]  ncols_q, ext_in_q, ext_out_q, in_q, out_q;
    logic [ADDR_W-1:0] addr_q, top_q;
    logic [IDX_W-1:0]  row_q, col_q;
    logic              valid_q, last_q, err_q, ready_q;

    logic [IDX_W-1:0]  w_ncols;
    logic [ADDR_W-1:0] w_start;
    logic              w_legal;

    logic              wrap_d, last_d;
    logic [IDX_W-1:0]  in_d, out_d, row_d, col_d;
    logic [ADDR_W-1:0] addr_d, top_d;

    // Setup math runs on the latched command, so it is stable during validation
    tile_base_calc #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .CFG_W  (CFG_W)
    ) u_base (
        .cfg_i       (cfg_q),
        .type_i      (type_q),
        .row_start_i (row_start_q),
        .col_start_i (col_start_q),
        .tile_rows_i (trows_q),
        .tile_cols_i (tcols_q),
        .ncols_o     (w_ncols),
        .start_o     (w_start),
        .legal_o     (w_legal)
    );

    // Next beat position: counters plus incremental address step
    always_comb begin
        wrap_d = (in_q == ext_in_q - IDX_W'(1));
        in_d   = wrap_d ? '0 : in_q + IDX_W'(1);
        out_d  = wrap_d ? out_q + IDX_W'(1) : out_q;
        last_d = (in_d == ext_in_q - IDX_W'(1)) && (out_d == ext_out_q - IDX_W'(1));
        addr_d = addr_q;
        top_d  = top_q;
        row_d  = row_q;
        col_d  = col_q;
        if (!cmaj_q) begin
            if (wrap_d) begin
                addr_d = addr_q + ADDR_W'(ncols_q) - ADDR_W'(tcols_q) + ADDR_W'(1);
                col_d  = col_start_q;
                row_d  = row_q + IDX_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                col_d  = col_q + IDX_W'(1);
            end
        end else begin
            if (wrap_d) begin
                // top_q tracks the origin-row address of the current column
                addr_d = top_q + ADDR_W'(1);
                top_d  = top_q + ADDR_W'(1);
                row_d  = row_start_q;
                col_d  = col_q + IDX_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(ncols_q);
                row_d  = row_q + IDX_W'(1);
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            cfg_q       <= '0;
            type_q      <= '0;
            row_start_q <= '0;
            col_start_q <= '0;
            trows_q     <= '0;
            tcols_q     <= '0;
            cmaj_q      <= 1'b0;
            ncols_q     <= '0;
            ext_in_q    <= '0;
            ext_out_q   <= '0;
            in_q        <= '0;
            out_q       <= '0;
            addr_q      <= '0;
            top_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        // Validation cycle: command was latched on the previous edge
                        pend_q <= 1'b0;
                        if (w_legal) begin
                            state_q   <= RUN;
                            ncols_q   <= w_ncols;
                            ext_in_q  <= cmaj_q ? trows_q : tcols_q;
                            ext_out_q <= cmaj_q ? tcols_q : trows_q;
                            in_q      <= '0;
                            out_q     <= '0;
                            addr_q    <= w_start;
                            top_q     <= w_start;
                            row_q     <= row_start_q;
                            col_q     <= col_start_q;
                            valid_q   <= 1'b1;
                            last_q    <= (trows_q == IDX_W'(1)) && (tcols_q == IDX_W'(1));
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end else if (i_Cmd_Valid && ready_q) begin
                        cfg_q       <= i_Config;
                        type_q      <= i_Type;
                        row_start_q <= i_Row_Start;
                        col_start_q <= i_Col_Start;
                        trows_q     <= i_Tile_Rows;
                        tcols_q     <= i_Tile_Cols;
                        cmaj_q      <= i_Col_Major;
                        pend_q      <= 1'b1;
                        ready_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (valid_q && i_Addr_Ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            in_q   <= in_d;
                            out_q  <= out_d;
                            addr_q <= addr_d;
                            top_q  <= top_d;
                            row_q  <= row_d;
                            col_q  <= col_d;
                            last_q <= last_d;
                        end
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_Cmd_Ready  = ready_q;
    assign o_Addr_Valid = valid_q;
    assign o_Address    = addr_q;
    assign o_Row        = row_q;
    assign o_Col        = col_q;
    assign o_Last       = last_q;
    assign o_Err        = err_q;

endmodule

`default_nettype wire

// File: doc/tile_address_sequencer.md
Name: tile_address_sequencer

Overview:
Parametrised successor of the single-shot index-to-address decoder. It accepts a tile command (matrix type, start row/col, tile extent, traversal order) and streams one memory address per cycle over a valid/ready handshake, walking the tile in row- or column-major order. It sits between the coprocessor control FSM and the shared matrix SRAM, so processing elements never compute addresses themselves.

Parameters:
ADDR_W, 10, width of o_Address; bounds the combined A/B/C footprint.
IDX_W, 8, width of the row/column index and tile-extent fields.
CFG_W, 32, config word width; fields are IDX_W bits each, packed from LSB.

Ports:
i_Clk  in  1  clock, rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Config  in  CFG_W  [7:0] lambda = rows of A/C; [15:8] gamma = cols of A = rows of B; [23:16] mu = cols of B/C; [31:24] processor count (unused here)
i_Cmd_Valid  in  1  command offered
o_Cmd_Ready  out  1  high only in IDLE
i_Type  in  3  one-hot: 001 = A, 010 = B, 100 = C
i_Row_Start, i_Col_Start  in  IDX_W  tile origin
i_Tile_Rows, i_Tile_Cols  in  IDX_W  tile extent, must be >= 1
i_Col_Major  in  1  0 = column index innermost; 1 = row index innermost
o_Addr_Valid  out  1  address beat valid
i_Addr_Ready  in  1  consumer accepts beat
o_Address  out  ADDR_W  linear SRAM address
o_Row, o_Col  out  IDX_W  absolute indices of the current beat
o_Last  out  1  final beat of the tile
o_Err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (asynchronous, active-low): state IDLE; o_Cmd_Ready = 1; o_Addr_Valid, o_Last and o_Err = 0; o_Address, o_Row and o_Col = 0. Reset mid-tile abandons the tile with no further beats.
- Address map, row-major per matrix: baseA = 0; baseB = lambda*gamma; baseC = baseB + gamma*mu. Address = base + row*ncols + col, where ncols = gamma (A), mu (B) or mu (C), and nrows = lambda (A), gamma (B) or lambda (C). All arithmetic is done at ADDR_W+IDX_W bits internally, then checked.
- States:
  - IDLE: on i_Cmd_Valid && o_Cmd_Ready, latch config and command, then validate.
  - RUN: emit beats.
  - ERR: one cycle, drives o_Err = 1, then returns to IDLE.
- Validation at acceptance moves the block to ERR instead of RUN if any of these holds:
  - type is not one-hot;
  - any dimension or tile extent is 0;
  - row_start + tile_rows > nrows, or col_start + tile_cols > ncols;
  - baseC + lambda*mu > 2^ADDR_W.
  A rejected command produces no beats.
- Latency: with the command accepted at edge N, the first beat is valid after edge N+1. Throughput is one beat per cycle while i_Addr_Ready = 1.
- Handshake: a beat transfers on o_Addr_Valid && i_Addr_Ready. While valid and not ready, o_Address, o_Row, o_Col and o_Last hold stable. o_Addr_Valid never drops without a transfer, except on reset.
- Counters: the inner counter wraps at its extent and then increments the outer counter. o_Last = 1 on beat tile_rows*tile_cols. After the last transfer the block returns to IDLE, and o_Cmd_Ready rises the following cycle; there is no command overlap.
- The address is updated incrementally, not by multiplication per beat:
  - row-major: +1 per beat, and on wrap + ncols - tile_cols + 1;
  - column-major: + ncols per beat, and on wrap back to the row-start address + 1.
  The single multiply happens only at acceptance.
- i_Config and command changes outside acceptance are ignored.

Decomposition:
- Package coproc_pkg holds:
  - type one-hot constants TYPE_A, TYPE_B, TYPE_C;
  - config field offsets and an IDX_W-wide field-extract function;
  - state encoding IDLE, RUN, ERR.
- Sub-module tile_base_calc, combinational: computes base, ncols, nrows, the start address and the legality flags from config, type and origin. The top level registers its outputs at acceptance.

Test Plan:
- Config 0x08040808 (lambda = 8, gamma = 8, mu = 4). A, origin (0,5), 1x3, row-major, ready held high -> addresses 5, 6, 7; o_Last on 7; first valid one cycle after acceptance.
- Same config. B, origin (2,1), 2x2, column-major -> baseB = 64: 64+9 = 73, 77, 74, 78; o_Last on 78.
- Same config. C, origin (3,0), 2x4, row-major, i_Addr_Ready toggling 1,0,0,1,… -> baseC = 96: 108..115 in order; outputs stable during stalls; exactly 8 transfers.
- A tile with row_start 7 and tile_rows 2; type 011; tile_cols 0 -> one o_Err pulse each; no o_Addr_Valid; o_Cmd_Ready returns after 2 cycles.
- Reset asserted on the 3rd beat of a 4x4 A tile -> all outputs take reset values immediately. A new 1x1 A tile at (0,0) issued afterwards -> single beat, address 0, o_Last = 1.
